// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths, special register numbers and the FIFO entry type for the RF write-back block
package rf_wb_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_HALT = 5'd30;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_ent_t;
endpackage

// File: rtl/m_wb_fifo.sv
// m_wb_fifo: DEPTH-entry FIFO of write-back entries; pointers carry an extra wrap bit to tell full from empty
module m_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_ent_t din,
  input  logic    pop,
  output wb_ent_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  wb_ent_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  // pointer advance; reset drops all contents at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  // storage write, no reset needed since empty pointers hide stale data
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/m_rf_wb.sv
// m_rf_wb: RF write-port controller merging ALU and buffered long-latency results, with pending-write scoreboard
// Optional halt-on-x30 feature enabled by defining RF_WB_HALT_EN.
module m_rf_wb
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_alu_v,
  input  logic [REG_AW-1:0] w_alu_rd,
  input  logic [XLEN-1:0]   w_alu_d,
  input  logic              w_lsu_v,
  output logic              w_lsu_rdy,
  input  logic [REG_AW-1:0] w_lsu_rd,
  input  logic [XLEN-1:0]   w_lsu_d,
  input  logic              w_iss_v,
  input  logic [REG_AW-1:0] w_iss_rd,
  input  logic [REG_AW-1:0] w_q_rs1,
  input  logic [REG_AW-1:0] w_q_rs2,
  output logic              w_q_busy1,
  output logic              w_q_busy2,
  output logic              w_we,
  output logic [REG_AW-1:0] w_wa,
  output logic [XLEN-1:0]   w_wd,
  output logic              w_halt
);
  wb_ent_t head;
  logic full, empty, push, pop, sel_v, nxt_we, we_lsu, halt;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0] sel_d;
  logic [31:0] sb, clr_mask, set_mask;
  assign w_lsu_rdy = ~full & ~halt;
  assign push = w_lsu_v & w_lsu_rdy;
  assign pop = ~w_alu_v & ~empty;
  assign sel_v = w_alu_v | ~empty;
  assign sel_rd = w_alu_v ? w_alu_rd : head.rd;
  assign sel_d = w_alu_v ? w_alu_d : head.data;
  assign nxt_we = sel_v & (sel_rd != REG_ZERO) & ~halt;
  assign w_halt = halt;
  assign w_q_busy1 = sb[w_q_rs1];
  assign w_q_busy2 = sb[w_q_rs2];
  assign clr_mask = (w_we & we_lsu) ? (32'd1 << w_wa) : 32'd0;
  assign set_mask = (w_iss_v && w_iss_rd != REG_ZERO) ? (32'd1 << w_iss_rd) : 32'd0;
  m_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(w_clk),
    .rst(w_rst),
    .push(push),
    .din('{rd: w_lsu_rd, data: w_lsu_d}),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // scoreboard: a committed FIFO write clears its bit, a same-cycle issue re-sets it
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) sb <= '0;
    else sb <= (sb & ~clr_mask) | set_mask;
  end
  // registered RF write port; ALU has priority over the FIFO head
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_we <= 1'b0;
      w_wa <= '0;
      w_wd <= '0;
      we_lsu <= 1'b0;
    end else begin
      w_we <= nxt_we;
      we_lsu <= ~w_alu_v;
      if (sel_v) begin
        w_wa <= sel_rd;
        w_wd <= sel_d;
      end
    end
  end
`ifdef RF_WB_HALT_EN
  // sticky halt raised by the same edge that issues a write to x30
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) halt <= 1'b0;
    else halt <= halt | (nxt_we & (sel_rd == REG_HALT));
  end
`else
  assign halt = 1'b0;
`endif
endmodule

// File: tb/tb_m_rf_wb.sv
// tb_m_rf_wb: directed stimulus with a queue-based reference model checked every cycle
module tb_m_rf_wb;
  import rf_wb_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic alu_v = 0, lsu_v = 0, iss_v = 0;
  logic [4:0] alu_rd = 0, lsu_rd = 0, iss_rd = 0, q1 = 0, q2 = 0;
  logic [31:0] alu_d = 0, lsu_d = 0;
  logic lsu_rdy, busy1, busy2, we, halt;
  logic [4:0] wa;
  logic [31:0] wd;
  int vectors = 0, errs = 0;

  m_rf_wb #(.DEPTH(DEPTH)) dut (
    .w_clk(clk), .w_rst(rst),
    .w_alu_v(alu_v), .w_alu_rd(alu_rd), .w_alu_d(alu_d),
    .w_lsu_v(lsu_v), .w_lsu_rdy(lsu_rdy), .w_lsu_rd(lsu_rd), .w_lsu_d(lsu_d),
    .w_iss_v(iss_v), .w_iss_rd(iss_rd),
    .w_q_rs1(q1), .w_q_rs2(q2), .w_q_busy1(busy1), .w_q_busy2(busy2),
    .w_we(we), .w_wa(wa), .w_wd(wd), .w_halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // reference model: results queue, pending set, expected write port
  wb_ent_t mq[$];
  wb_ent_t s;
  bit pend[32];
  bit m_we, m_lsu, m_halt, s_v, rdy_now;
  logic [4:0] m_wa;
  logic [31:0] m_wd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      foreach (pend[i]) pend[i] = 0;
      m_we = 0; m_wa = 0; m_wd = 0; m_lsu = 0; m_halt = 0;
    end else begin
      rdy_now = mq.size() < DEPTH && !m_halt;
      if (m_we && m_lsu) pend[m_wa] = 0;
      if (iss_v && iss_rd != 0) pend[iss_rd] = 1;
      s_v = 1;
      m_lsu = !alu_v;
      if (alu_v) s = '{rd: alu_rd, data: alu_d};
      else if (mq.size() > 0) s = mq.pop_front();
      else s_v = 0;
      if (lsu_v && rdy_now) mq.push_back('{rd: lsu_rd, data: lsu_d});
      m_we = s_v && s.rd != 0 && !m_halt;
      if (m_we) begin m_wa = s.rd; m_wd = s.data; end
`ifdef RF_WB_HALT_EN
      if (m_we && s.rd == 5'd30) m_halt = 1;
`endif
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("we", we, m_we);
      if (m_we) begin
        chk("wa", wa, m_wa);
        chk("wd", wd, m_wd);
      end
      chk("lsu_rdy", lsu_rdy, (mq.size() < DEPTH && !m_halt));
      chk("busy1", busy1, (q1 != 0 && pend[q1]));
      chk("busy2", busy2, (q2 != 0 && pend[q2]));
      chk("halt", halt, m_halt);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    cyc(2);
    chk("rst_we", we, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_halt", halt, 0);
    rst = 0;
    #1 chk("rst_rdy", lsu_rdy, 1);
    cyc(1);
    // ALU write and x0 discard
    alu_v = 1; alu_rd = 5; alu_d = 32'h1234;
    cyc(1);
    alu_rd = 0; alu_d = 32'hdead;
    chk("alu_we", we, 1);
    chk("alu_wa", wa, 5);
    chk("alu_wd", wd, 32'h1234);
    cyc(1);
    alu_v = 0;
    chk("x0_we", we, 0);
    cyc(1);
    // issue then long-latency result to x7
    iss_v = 1; iss_rd = 7; q1 = 7; q2 = 0;
    cyc(1);
    iss_v = 0; lsu_v = 1; lsu_rd = 7; lsu_d = 32'hab;
    #1 chk("p7_busy_a", busy1, 1);
    chk("q0_busy", busy2, 0);
    cyc(1);
    lsu_v = 0;
    chk("p7_busy_b", busy1, 1);
    chk("p7_we0", we, 0);
    cyc(1);
    chk("p7_we", we, 1);
    chk("p7_wa", wa, 7);
    chk("p7_wd", wd, 32'hab);
    chk("p7_busy_c", busy1, 1);
    cyc(1);
    chk("p7_clear", busy1, 0);
    // issue to x0 never pending
    iss_v = 1; iss_rd = 0; q2 = 0;
    cyc(1);
    iss_v = 0;
    chk("iss_x0", busy2, 0);
    // FIFO fill under continuous ALU traffic
    alu_v = 1; alu_rd = 1;
    for (int i = 0; i < 5; i++) begin
      alu_d = 32'h100 + i;
      lsu_v = 1; lsu_rd = 5'(10 + i); lsu_d = 32'hc00 + i;
      cyc(1);
    end
    chk("full_rdy", lsu_rdy, 0);
    lsu_v = 0; alu_v = 0;
    cyc(1);
    chk("drain0_wa", wa, 10);
    chk("drain0_wd", wd, 32'hc00);
    cyc(1);
    chk("drain1_wa", wa, 11);
    cyc(3);
    chk("drained_we", we, 0);
    // set wins over clear for x3
    iss_v = 1; iss_rd = 3; q1 = 3;
    cyc(1);
    iss_v = 0; lsu_v = 1; lsu_rd = 3; lsu_d = 32'h33;
    cyc(1);
    lsu_v = 0;
    cyc(1);
    chk("x3_we", we, 1);
    iss_v = 1; iss_rd = 3;
    cyc(1);
    iss_v = 0;
    chk("x3_setwins", busy1, 1);
    cyc(2);
    chk("x3_still", busy1, 1);
    // async reset with queued entries and pending bits
    iss_v = 1; iss_rd = 8;
    cyc(1);
    iss_rd = 9;
    alu_v = 1; alu_rd = 2; lsu_v = 1;
    for (int i = 0; i < 3; i++) begin
      lsu_rd = 5'(20 + i); lsu_d = 32'he0 + i;
      cyc(1);
      iss_v = 0;
    end
    q1 = 8; q2 = 9;
    #1 rst = 1;
    #1 chk("arst_we", we, 0);
    chk("arst_wa", wa, 0);
    chk("arst_wd", wd, 0);
    chk("arst_busy1", busy1, 0);
    chk("arst_busy2", busy2, 0);
    alu_v = 0; lsu_v = 0;
    cyc(2);
    rst = 0;
    cyc(6);
    chk("post_rst_we", we, 0);
    // x30 as a write target
    alu_v = 1; alu_rd = 30; alu_d = 32'h30;
    cyc(1);
    alu_rd = 4; alu_d = 32'h4;
    cyc(1);
    alu_v = 0;
`ifdef RF_WB_HALT_EN
    chk("halt_set", halt, 1);
    chk("halt_block", we, 0);
`else
    chk("x30_halt", halt, 0);
    chk("x30_next_we", we, 1);
    chk("x30_next_wa", wa, 4);
`endif
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
